// File: rtl/vram_port.sv
// vram_port: single-port video byte RAM, video fetch priority, CPU write FIFO.
// Define VRAM_FWD_EN to forward queued CPU writes to video reads.
module vram_port #(
   parameter int RAM_AW     = 17,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                         clk_vid,
   input  logic                         reset_n,
   input  logic                         ce_pix,
   input  logic [22:0]                  video_addr,
   output logic [7:0]                   video_data,
   input  logic                         cpu_we,
   input  logic [22:0]                  cpu_addr,
   input  logic [7:0]                   cpu_din,
   output logic                         cpu_ready,
   output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
   output logic                         ovf_sticky
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int LW = PW + 1;

   logic [RAM_AW-1:0] fa_q [FIFO_DEPTH];
   logic [7:0]        fd_q [FIFO_DEPTH];
   logic [7:0]        mem_q [2**RAM_AW];
   logic [7:0]        ram_q;

   logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
   logic [LW-1:0] lvl_q, lvl_d;
   logic          ovf_q, ovf_d;
   logic          rd_pend_q;
   logic [7:0]    vd_q, vd_d;
   logic          full, empty, push, pop, ram_we;
   logic [RAM_AW-1:0] vaddr, caddr;
   logic          unused_hi;

   assign vaddr      = video_addr[RAM_AW-1:0];
   assign caddr      = cpu_addr[RAM_AW-1:0];
   assign unused_hi  = ^{video_addr[22:RAM_AW], cpu_addr[22:RAM_AW]};

   assign full       = (lvl_q == LW'(FIFO_DEPTH));
   assign empty      = (lvl_q == '0);
   assign cpu_ready  = ~full;
   assign push       = cpu_we & ~full;
   // Video owns the RAM on ce_pix cycles; drain only in the gaps.
   assign pop        = ~ce_pix & ~empty;
   assign ram_we     = pop;

   assign fifo_level = lvl_q;
   assign ovf_sticky = ovf_q;
   assign video_data = vd_q;

`ifdef VRAM_FWD_EN
   logic       fh_d, fh_q;
   logic [7:0] fdat_d, fdat_q;

   // Scan oldest to youngest so the youngest match wins.
   always_comb begin
      fh_d   = 1'b0;
      fdat_d = '0;
      for (int k = 0; k < FIFO_DEPTH; k++) begin
         if (LW'(k) < lvl_q &&
             fa_q[rp_q + PW'(k)] == vaddr) begin
            fh_d   = 1'b1;
            fdat_d = fd_q[rp_q + PW'(k)];
         end
      end
   end

   always_ff @(posedge clk_vid or negedge reset_n) begin
      if (!reset_n) begin
         fh_q   <= 1'b0;
         fdat_q <= '0;
      end else begin
         fh_q   <= fh_d;
         fdat_q <= fdat_d;
      end
   end
`endif

   always_comb begin
      wp_d  = wp_q;
      rp_d  = rp_q;
      lvl_d = lvl_q;
      ovf_d = ovf_q | (cpu_we & full);
      if (push) wp_d = wp_q + PW'(1);
      if (pop)  rp_d = rp_q + PW'(1);
      case ({push, pop})
         2'b10:   lvl_d = lvl_q + LW'(1);
         2'b01:   lvl_d = lvl_q - LW'(1);
         default: lvl_d = lvl_q;
      endcase
      vd_d = vd_q;
`ifdef VRAM_FWD_EN
      if (rd_pend_q) vd_d = fh_q ? fdat_q : ram_q;
`else
      if (rd_pend_q) vd_d = ram_q;
`endif
   end

   always_ff @(posedge clk_vid or negedge reset_n) begin
      if (!reset_n) begin
         wp_q      <= '0;
         rp_q      <= '0;
         lvl_q     <= '0;
         ovf_q     <= 1'b0;
         rd_pend_q <= 1'b0;
         vd_q      <= '0;
      end else begin
         wp_q      <= wp_d;
         rp_q      <= rp_d;
         lvl_q     <= lvl_d;
         ovf_q     <= ovf_d;
         rd_pend_q <= ce_pix;
         vd_q      <= vd_d;
      end
   end

   // Storage arrays carry no reset; pointers and level gate their use.
   always_ff @(posedge clk_vid) begin
      if (ce_pix)      ram_q <= mem_q[vaddr];
      else if (ram_we) mem_q[fa_q[rp_q]] <= fd_q[rp_q];
      if (push) begin
         fa_q[wp_q] <= caddr;
         fd_q[wp_q] <= cpu_din;
      end
   end

endmodule

// File: tb/tb_vram_port.sv
// tb_vram_port: scoreboard bench for vram_port read latency, FIFO drain,
// overflow, write ordering, priority and asynchronous reset.
module tb_vram_port;

   logic        clk_vid = 1'b0;
   logic        reset_n = 1'b0;
   logic        ce_pix  = 1'b0;
   logic [22:0] video_addr = '0;
   logic [7:0]  video_data;
   logic        cpu_we  = 1'b0;
   logic [22:0] cpu_addr = '0;
   logic [7:0]  cpu_din  = '0;
   logic        cpu_ready;
   logic [2:0]  fifo_level;
   logic        ovf_sticky;

   int checks = 0;
   int errors = 0;
   logic [7:0] exp_q[$];
   logic [7:0] last_exp = '0;
   logic       s1 = 1'b0;

   vram_port #(.RAM_AW(17), .FIFO_DEPTH(4)) dut (
      .clk_vid    (clk_vid),
      .reset_n    (reset_n),
      .ce_pix     (ce_pix),
      .video_addr (video_addr),
      .video_data (video_data),
      .cpu_we     (cpu_we),
      .cpu_addr   (cpu_addr),
      .cpu_din    (cpu_din),
      .cpu_ready  (cpu_ready),
      .fifo_level (fifo_level),
      .ovf_sticky (ovf_sticky)
   );

   always #5 clk_vid = ~clk_vid;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Monitor: a read sampled at edge N must show up right after edge N+1.
   initial begin
      logic       c;
      logic [7:0] e;
      forever begin
         @(posedge clk_vid);
         c  = s1;
         s1 = ce_pix && reset_n;
         #1;
         if (!reset_n) begin
            s1       = 1'b0;
            last_exp = '0;
         end else if (c) begin
            if (exp_q.size() == 0) begin
               chk("sb_underflow", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk("rd_data", {24'd0, video_data}, {24'd0, e});
               last_exp = e;
            end
         end else begin
            chk("rd_hold", {24'd0, video_data}, {24'd0, last_exp});
         end
      end
   end

   // No RAM write may ever coincide with a video fetch cycle.
   initial begin
      forever begin
         @(negedge clk_vid);
         #2;
         if (reset_n && ce_pix) chk("prio_no_wr", {31'd0, dut.ram_we}, 32'd0);
      end
   end

   task automatic step(input logic ce, input logic we,
                       input logic [22:0] va, input logic [22:0] ca,
                       input logic [7:0] d, input logic [7:0] e);
      @(negedge clk_vid);
      ce_pix     = ce;
      cpu_we     = we;
      video_addr = va;
      cpu_addr   = ca;
      cpu_din    = d;
      if (ce) exp_q.push_back(e);
      @(posedge clk_vid);
      #1;
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 23'h0, 23'h0, 8'h00, 8'h00);
   endtask

   task automatic rd(input logic [22:0] a, input logic [7:0] e);
      step(1'b1, 1'b0, a, 23'h0, 8'h00, e);
      idle();
   endtask

   task automatic lvl(input string nm, input int e);
      chk(nm, {29'd0, fifo_level}, e);
   endtask

   initial begin
      int lv [10] = '{1, 1, 2, 2, 3, 3, 4, 3, 4, 3};
      logic [22:0] wa;
      logic [7:0]  fwd_exp;

      repeat (3) @(posedge clk_vid);
      #1;
      chk("rst_vdata", {24'd0, video_data}, 32'h0);
      lvl("rst_level", 0);
      chk("rst_ready", {31'd0, cpu_ready}, 32'd1);
      chk("rst_ovf", {31'd0, ovf_sticky}, 32'd0);
      @(negedge clk_vid);
      reset_n = 1'b1;

      // Preload and drain.
      step(1'b0, 1'b1, 23'h0, 23'h12000, 8'hA5, 8'h00);
      lvl("pre_lvl1", 1);
      idle();
      lvl("pre_lvl0", 0);
      step(1'b0, 1'b1, 23'h0, 23'h19E00, 8'h3C, 8'h00);
      lvl("drain_lvl1", 1);
      idle();
      lvl("drain_lvl0", 0);

      // Read latency with ce_pix every 4 cycles; high address bits ignored.
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b0, (i == 2) ? 23'h712000 : 23'h012000,
              23'h0, 8'h00, 8'hA5);
         idle();
         idle();
         idle();
      end
      rd(23'h19E00, 8'h3C);

      // Stale read of queued address, and ordering of same-address writes.
      step(1'b0, 1'b1, 23'h0, 23'h00400, 8'h5A, 8'h00);
      idle();
      step(1'b0, 1'b1, 23'h0, 23'h00401, 8'h77, 8'h00);
      lvl("q_a", 1);
      step(1'b1, 1'b1, 23'h12000, 23'h00402, 8'h88, 8'hA5);
      lvl("q_b", 2);
      step(1'b0, 1'b1, 23'h0, 23'h00400, 8'h11, 8'h00);
      lvl("q_c", 2);
      step(1'b1, 1'b1, 23'h12000, 23'h00400, 8'h22, 8'hA5);
      lvl("q_d", 3);
      idle();
      lvl("q_e", 2);
`ifdef VRAM_FWD_EN
      fwd_exp = 8'h22;
`else
      fwd_exp = 8'h5A;
`endif
      step(1'b1, 1'b0, 23'h00400, 23'h0, 8'h00, fwd_exp);
      lvl("q_f", 2);
      idle();
      idle();
      lvl("q_drained", 0);
      rd(23'h00400, 8'h22);
      rd(23'h00401, 8'h77);
      rd(23'h00402, 8'h88);

      // Back-to-back writes with ce_pix every other cycle until overflow.
      for (int i = 1; i <= 10; i++) begin
         wa = (i == 8)  ? 23'h1007 :
              (i == 10) ? 23'h1009 : 23'(32'h1000 + i);
         step(i[0], 1'b1, 23'h12000, wa, 8'(8'hB0 + i), 8'hA5);
         lvl($sformatf("ovf_lvl%0d", i), lv[i-1]);
         chk($sformatf("ovf_rdy%0d", i), {31'd0, cpu_ready},
             (lv[i-1] == 4) ? 32'd0 : 32'd1);
         chk($sformatf("ovf_stk%0d", i), {31'd0, ovf_sticky},
             (i >= 8) ? 32'd1 : 32'd0);
      end
      step(1'b0, 1'b0, 23'h0, 23'h0, 8'h00, 8'h00);
      idle();
      idle();
      lvl("ovf_drained", 0);
      rd(23'h01001, 8'hB1);
      rd(23'h01006, 8'hB6);
      rd(23'h01007, 8'hB7);
      rd(23'h01009, 8'hB9);

      // Asynchronous reset with a queued write and a pending read.
      step(1'b0, 1'b1, 23'h0, 23'h00500, 8'h99, 8'h00);
      step(1'b1, 1'b1, 23'h12000, 23'h00501, 8'h98, 8'hA5);
      lvl("mid_lvl", 2);
      #2;
      reset_n = 1'b0;
      exp_q.delete();
      #1;
      chk("mid_vdata", {24'd0, video_data}, 32'h0);
      lvl("mid_level", 0);
      chk("mid_ready", {31'd0, cpu_ready}, 32'd1);
      chk("mid_ovf", {31'd0, ovf_sticky}, 32'd0);
      @(negedge clk_vid);
      ce_pix = 1'b0;
      cpu_we = 1'b0;
      repeat (2) @(negedge clk_vid);
      reset_n = 1'b1;
      idle();
      lvl("post_rst_lvl", 0);
      rd(23'h12000, 8'hA5);
      idle();
      chk("sb_empty", exp_q.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
